// File: rtl/reset_sequencer_pkg.sv
// Shared types and constants for the reset sequencer.
// Contents:
//   state_t                      - sequencer FSM states
//   ORDER_ASCENDING/DESCENDING   - encodings for release_order_p
//   max_int                      - elaboration-time helper for sizing
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_IDLE    = 2'd2
    } state_t;

    localparam int ORDER_ASCENDING  = 0;
    localparam int ORDER_DESCENDING = 1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_seq_tc_counter.sv
// Terminal-count counter used to time the hold and stagger intervals.
// Ports:
//   clk_i      - clock, rising edge
//   reset_i    - synchronous active-high reset, zeroes the count
//   clear_i    - synchronous clear, zeroes the count
//   enable_i   - count one step per cycle while high
//   terminal_i - last count value; the counter wraps to zero after it
//   done_o     - high in the enabled cycle whose count equals terminal_i
module reset_seq_tc_counter
    import reset_sequencer_pkg::*;
#(
    parameter int width_p = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               enable_i,
    input  logic [width_p-1:0] terminal_i,
    output logic               done_o
);

    logic [width_p-1:0] count_r;

    // Flag the terminal cycle; the caller acts on it at the coming edge.
    assign done_o = enable_i && (count_r == terminal_i);

    // Count register: wraps to zero on the terminal edge so the next interval starts clean.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_r <= {width_p{1'b0}};
        end else if (clear_i) begin
            count_r <= {width_p{1'b0}};
        end else if (enable_i) begin
            if (count_r == terminal_i) begin
                count_r <= {width_p{1'b0}};
            end else begin
                count_r <= count_r + width_p'(1);
            end
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Staggered reset sequencer: holds every reset channel asserted for
// assert_cycles_p cycles, then releases one channel every stagger_cycles_p
// cycles in ascending or descending order. A trigger restarts the sequence.
// Ports:
//   clk_i       - clock, rising edge
//   reset_i     - synchronous active-high reset; sequence restarts when it falls
//   trigger_i   - single-cycle restart request (accepted in any state)
//   resets_o    - per-channel active-high resets (registered)
//   busy_o      - high while a sequence is in progress (registered)
//   done_o      - one-cycle pulse when the last channel releases (registered)
//   seq_count_o - completed-sequence counter, wraps (registered)
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int num_resets_p     = 4,
    parameter int assert_cycles_p  = 10,
    parameter int stagger_cycles_p = 10,
    parameter int release_order_p  = ORDER_ASCENDING,
    parameter int count_width_p    = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     trigger_i,
    output logic [num_resets_p-1:0]  resets_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [count_width_p-1:0] seq_count_o
);

    localparam int CNT_W = $clog2(max_int(assert_cycles_p, stagger_cycles_p) + 1);
    localparam int IDX_W = $clog2(num_resets_p + 1);

    localparam logic [CNT_W-1:0] ASSERT_TERM  = CNT_W'(assert_cycles_p - 1);
    localparam logic [CNT_W-1:0] STAGGER_TERM = CNT_W'(stagger_cycles_p - 1);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(num_resets_p - 1);

    if (num_resets_p < 1) begin : g_bad_num_resets
        $error("reset_sequencer: num_resets_p must be >= 1");
    end
    if (assert_cycles_p < 1) begin : g_bad_assert_cycles
        $error("reset_sequencer: assert_cycles_p must be >= 1");
    end
    if (stagger_cycles_p < 1) begin : g_bad_stagger_cycles
        $error("reset_sequencer: stagger_cycles_p must be >= 1");
    end
    if (release_order_p != ORDER_ASCENDING && release_order_p != ORDER_DESCENDING) begin : g_bad_order
        $error("reset_sequencer: release_order_p must be 0 or 1");
    end
    if (count_width_p < 1) begin : g_bad_count_width
        $error("reset_sequencer: count_width_p must be >= 1");
    end

    state_t                     state_r, state_s;
    logic [IDX_W-1:0]           idx_r, idx_s;
    logic [IDX_W-1:0]           chan_s;
    logic [num_resets_p-1:0]    resets_r, resets_s;
    logic                       busy_r, busy_s;
    logic                       done_r, done_s;
    logic [count_width_p-1:0]   seq_count_r, seq_count_s;
    logic                       cnt_clear_s;
    logic                       cnt_enable_s;
    logic                       cnt_done_s;
    logic [CNT_W-1:0]           cnt_terminal_s;

    reset_seq_tc_counter #(
        .width_p (CNT_W)
    ) u_timer (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .clear_i    (cnt_clear_s),
        .enable_i   (cnt_enable_s),
        .terminal_i (cnt_terminal_s),
        .done_o     (cnt_done_s)
    );

    // Next-state and output logic; idx_r counts channels already released.
    always_comb begin
        state_s        = state_r;
        idx_s          = idx_r;
        resets_s       = resets_r;
        busy_s         = busy_r;
        done_s         = 1'b0;
        seq_count_s    = seq_count_r;
        cnt_clear_s    = 1'b0;
        cnt_enable_s   = 1'b0;
        if (state_r == ST_RELEASE) begin
            cnt_terminal_s = STAGGER_TERM;
        end else begin
            cnt_terminal_s = ASSERT_TERM;
        end
        if (release_order_p == ORDER_DESCENDING) begin
            chan_s = LAST_IDX - idx_r;
        end else begin
            chan_s = idx_r;
        end

        if (trigger_i) begin
            // Restart wins over any release, including the final one.
            state_s     = ST_ASSERT;
            idx_s       = {IDX_W{1'b0}};
            resets_s    = {num_resets_p{1'b1}};
            busy_s      = 1'b1;
            cnt_clear_s = 1'b1;
        end else begin
            case (state_r)
                ST_ASSERT, ST_RELEASE: begin
                    cnt_enable_s = 1'b1;
                    busy_s       = 1'b1;
                    if (cnt_done_s) begin
                        for (int b = 0; b < num_resets_p; b++) begin
                            if (b == int'(chan_s)) begin
                                resets_s[b] = 1'b0;
                            end else begin
                                resets_s[b] = resets_r[b];
                            end
                        end
                        idx_s = idx_r + IDX_W'(1);
                        if (idx_r == LAST_IDX) begin
                            state_s     = ST_IDLE;
                            busy_s      = 1'b0;
                            done_s      = 1'b1;
                            seq_count_s = seq_count_r + count_width_p'(1);
                        end else begin
                            state_s = ST_RELEASE;
                        end
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_IDLE: begin
                    busy_s = 1'b0;
                end
                default: begin
                    state_s     = ST_ASSERT;
                    idx_s       = {IDX_W{1'b0}};
                    resets_s    = {num_resets_p{1'b1}};
                    busy_s      = 1'b1;
                    cnt_clear_s = 1'b1;
                end
            endcase
        end
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r     <= ST_ASSERT;
            idx_r       <= {IDX_W{1'b0}};
            resets_r    <= {num_resets_p{1'b1}};
            busy_r      <= 1'b1;
            done_r      <= 1'b0;
            seq_count_r <= {count_width_p{1'b0}};
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            resets_r    <= resets_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            seq_count_r <= seq_count_s;
        end
    end

    assign resets_o    = resets_r;
    assign busy_o      = busy_r;
    assign done_o      = done_r;
    assign seq_count_o = seq_count_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench: four configurations share clock, reset and trigger.
// A timeline model (edges elapsed since the sequence start) predicts the
// outputs; predictions are queued when stimulus is driven and popped after
// the edge to compare against each DUT.
module tb_reset_sequencer;

    typedef struct packed {
        logic [3:0] rs;
        logic       busy;
        logic       done;
        logic [7:0] cnt;
    } exp_t;

    // Per-instance configuration: default, descending, single channel, 2-bit count.
    localparam int P_N  [0:3] = '{4, 4, 1, 4};
    localparam int P_A  [0:3] = '{10, 10, 3, 10};
    localparam int P_S  [0:3] = '{10, 10, 10, 10};
    localparam int P_O  [0:3] = '{0, 1, 0, 0};
    localparam int P_CW [0:3] = '{8, 8, 8, 2};

    logic       clk;
    logic       reset;
    logic       trigger;
    logic [3:0] rs0, rs1, rs3;
    logic [0:0] rs2;
    logic       b0, b1, b2, b3;
    logic       d0, d1, d2, d3;
    logic [7:0] c0, c1, c2;
    logic [1:0] c3;

    int   tests;
    int   fails;
    int   cyc;
    int   t_m   [0:3];
    int   cnt_m [0:3];
    exp_t q     [$];

    reset_sequencer u0 (
        .clk_i(clk), .reset_i(reset), .trigger_i(trigger),
        .resets_o(rs0), .busy_o(b0), .done_o(d0), .seq_count_o(c0)
    );
    reset_sequencer #(.release_order_p(1)) u1 (
        .clk_i(clk), .reset_i(reset), .trigger_i(trigger),
        .resets_o(rs1), .busy_o(b1), .done_o(d1), .seq_count_o(c1)
    );
    reset_sequencer #(.num_resets_p(1), .assert_cycles_p(3)) u2 (
        .clk_i(clk), .reset_i(reset), .trigger_i(trigger),
        .resets_o(rs2), .busy_o(b2), .done_o(d2), .seq_count_o(c2)
    );
    reset_sequencer #(.count_width_p(2)) u3 (
        .clk_i(clk), .reset_i(reset), .trigger_i(trigger),
        .resets_o(rs3), .busy_o(b3), .done_o(d3), .seq_count_o(c3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Predict one instance's outputs after the coming edge.
    function automatic exp_t model_step(input int d, input logic rst, input logic trg);
        exp_t e;
        int   last;
        int   p;
        e = '0;
        if (rst || trg) begin
            t_m[d] = 0;
            if (rst) cnt_m[d] = 0;
            for (int k = 0; k < P_N[d]; k++) e.rs[k] = 1'b1;
            e.busy = 1'b1;
            e.done = 1'b0;
        end else begin
            if (t_m[d] < 100000) t_m[d] = t_m[d] + 1;
            last = P_A[d] + (P_N[d] - 1) * P_S[d];
            for (int k = 0; k < P_N[d]; k++) begin
                p = (P_O[d] == 1) ? (P_N[d] - 1 - k) : k;
                e.rs[k] = (t_m[d] < P_A[d] + p * P_S[d]);
            end
            e.done = (t_m[d] == last);
            e.busy = (t_m[d] < last);
            if (e.done) cnt_m[d] = (cnt_m[d] + 1) % (1 << P_CW[d]);
        end
        e.cnt = 8'(cnt_m[d]);
        return e;
    endfunction

    task automatic chk(input string tag, input int d, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s dut=%0d cycle=%0d observed=%0h expected=%0h", tag, d, cyc, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue predictions, then compare after the edge.
    task automatic step(input logic rst, input logic trg);
        exp_t e;
        exp_t o;
        reset   = rst;
        trigger = trg;
        for (int d = 0; d < 4; d++) q.push_back(model_step(d, rst, trg));
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < 4; d++) begin
            e = q.pop_front();
            case (d)
                0: o = '{rs: rs0,       busy: b0, done: d0, cnt: c0};
                1: o = '{rs: rs1,       busy: b1, done: d1, cnt: c1};
                2: o = '{rs: 4'(rs2),   busy: b2, done: d2, cnt: c2};
                default: o = '{rs: rs3, busy: b3, done: d3, cnt: 8'(c3)};
            endcase
            chk("resets",    d, 8'(o.rs),   8'(e.rs));
            chk("busy",      d, 8'(o.busy), 8'(e.busy));
            chk("done",      d, 8'(o.done), 8'(e.done));
            chk("seq_count", d, o.cnt,      e.cnt);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        cyc     = 0;
        reset   = 1'b1;
        trigger = 1'b0;
        for (int d = 0; d < 4; d++) begin
            t_m[d]   = 0;
            cnt_m[d] = 0;
        end

        // Held in reset, then a full automatic sequence.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        run(45);

        // Trigger from IDLE, full sequence.
        step(1'b0, 1'b1);
        run(45);

        // Abort after bits 0 and 1 are released (trigger on edge 25).
        step(1'b0, 1'b1);
        run(24);
        step(1'b0, 1'b1);
        run(45);

        // Trigger coinciding with the completion edge 40.
        step(1'b0, 1'b1);
        run(39);
        step(1'b0, 1'b1);
        run(45);

        // Reset pulsed at edge 32, then automatic restart.
        step(1'b0, 1'b1);
        run(31);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        run(45);

        // Three more sequences so the 2-bit counter wraps to 0.
        for (int s = 0; s < 3; s++) begin
            step(1'b0, 1'b1);
            run(45);
        end

        // Trigger while held in reset: reset wins.
        step(1'b1, 1'b1);
        run(12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
